// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell, time-shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first,
// one bit per clock, with valid/ready handshakes on both sides.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic             carry, ovf_r;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic             accept, last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = (state == ST_IDLE) && in_valid;
    assign last_bit = (cnt == LAST);

    // Sum register shifted right with the newest bit entering at the MSB.
    always_comb begin
        sum_nxt            = sum_sh >> 1;
        sum_nxt[WIDTH-1]   = fa_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state logic: IDLE -> RUN on accept, RUN for WIDTH bits, DONE until consumed.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (in_valid)  state_n = ST_RUN;
            ST_RUN:  if (last_bit)  state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default:                state_n = ST_IDLE;
        endcase
    end

    // Operand/sum shift registers, carry, bit counter and overflow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            // Carry into the MSB is the carry register on the last bit.
            if (last_bit) ovf_r <= carry ^ fa_cout;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign sum       = sum_sh;
    assign cout      = carry;
    assign ovf       = ovf_r;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition controller. It time-shares one full_adder cell across a WIDTH-bit operation, LSB first.
- It holds the carry between cycles, assembles the sum in a shift register, and returns sum, carry-out and a signed-overflow flag.
- Valid/ready handshakes on both input and output. This is the area-minimal adder path for arithmetic units that are not latency-critical.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b and cin are presented.
- in_ready  output  1  controller can accept operands (high only in IDLE).
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset (async assert): state=IDLE; a_sh, b_sh, sum_sh, carry, ovf, bit counter all cleared.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Reset mid-operation aborts the operation with no output. The first accept after deassertion starts a fresh operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a clock edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - in_valid is ignored in every other state.
- RUN: one bit per cycle. The full_adder inputs are a_sh[0], b_sh[0] and carry. At each edge:
  - sum_sh shifts right, with the fa sum entering bit WIDTH-1.
  - a_sh and b_sh shift right.
  - carry<=fa cout.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1: ovf<=carry^fa_cout, and state<=DONE. So RUN lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1. sum=sum_sh, cout=carry, ovf registered.
  - On out_ready at an edge: state<=IDLE.
  - While out_ready=0, sum/cout/ovf/out_valid hold stable; in_ready stays 0.
- Latency: out_valid rises WIDTH edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles with out_ready tied high. No overlap of operations.
- Output values after leaving DONE: sum/cout/ovf keep their last values but are meaningful only while out_valid=1.
- Counter width: max(1, $clog2(WIDTH)). With WIDTH=1, RUN lasts one cycle and ovf=cin^cout.
- Arithmetic: sum+cout = a+b+cin, modulo 2^(WIDTH+1) (exact, unsigned).

Decomposition:
- Package serial_add_pkg:
  - typedef enum state_t {ST_IDLE, ST_RUN, ST_DONE}.
  - Constant DEFAULT_WIDTH=8.
- Sub-module: exactly one instance of the existing full_adder cell (a, b, cin, sum, cout). No other sub-modules. Shift registers and the FSM are local.

Test Plan:
- Basic add, WIDTH=8: a=8'h5A, b=8'h3C, cin=0 -> sum=8'h96, cout=0, ovf=1. out_valid rises exactly 8 edges after the accept edge; busy=1 throughout.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Also a=8'h80, b=8'h80, cin=1 -> sum=8'h01, cout=1, ovf=1.
- Backpressure: complete an add of a=8'h12, b=8'h34 and hold out_ready=0 for 5 cycles with in_valid=1 and new operands.
  - During the stall: out_valid=1 and sum=8'h46 stay stable, in_ready=0, and the new operands are not captured.
  - After out_ready=1: IDLE, in_ready=1.
- Reset mid-RUN: assert rst_n=0 asynchronously during the 3rd RUN cycle.
  - Immediately: out_valid=0, busy=0, sum=0.
  - After release: in_ready=1. The next op a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Back-to-back: out_ready=1 and in_valid=1 held continuously with operand pairs (8'h01,8'h01) then (8'h7F,8'h01).
  - Accepts occur 10 cycles apart.
  - Results in order: 8'h02/ovf=0, then 8'h80/ovf=1.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0. out_valid one edge after accept.
